edge_event_unit: RTL and testbench

- Multi-channel, parametrised successor to the single-bit dual-edge detectors.
- Each channel: metastability synchroniser, glitch filter, per-channel mode select (rise/fall/both/off), one-cycle edge pulse, sticky pending flag, saturating event counter.
- Aggregated interrupt output.
- Sits between raw asynchronous inputs (buttons, sensor lines) and control FSMs or a register interface.

---
 rtl/edge_event_pkg.sv | 26 ++
 rtl/edge_event_chan.sv | 97 +++++++++
 rtl/edge_event_unit.sv | 46 ++++
 tb/tb_edge_event_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the multi-channel edge event unit.
package edge_event_pkg;

    typedef enum logic [1:0] {
        e_off  = 2'b00,
        e_rise = 2'b01,
        e_fall = 2'b10,
        e_both = 2'b11
    } t_edge_mode;

    typedef enum logic {
        e_stable = 1'b0,
        e_pend   = 1'b1
    } t_filt_state;

    // True when a toggle away from old_lvl counts as an event under mode.
    function automatic logic edge_qualifies(input t_edge_mode mode, input logic old_lvl);
        case (mode)
            e_rise:  return !old_lvl;
            e_fall:  return old_lvl;
            e_both:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One input channel: synchroniser, glitch filter, edge pulse, sticky flag
// and saturating event counter.
module edge_event_chan
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lvl,
    input  t_edge_mode       i_mode,
    input  logic             i_clr,
    output logic             o_lvl,
    output logic             o_edge,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_count
);

    localparam int FILT_W = $clog2(FILT_CYC + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    t_filt_state            state;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   toggle;
    logic                   event_now;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_lvl};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: defaults first so every path assigns every output (no latch inferred).
    always_comb begin
        toggle    = 1'b0;
        event_now = 1'b0;
        if (s != o_lvl) begin
            case (state)
                e_stable: toggle = (FILT_CYC == 1);
                e_pend:   toggle = (filt_cnt == FILT_LAST);
                default:  toggle = 1'b0;
            endcase
        end
        event_now = toggle && edge_qualifies(i_mode, o_lvl);
    end

    // Filter FSM: a new level is accepted only after FILT_CYC consecutive
    // differing samples; any return to o_lvl restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= e_stable;
            filt_cnt <= '0;
            o_lvl    <= 1'b0;
        end else if (s == o_lvl) begin
            state    <= e_stable;
            filt_cnt <= '0;
        end else if (toggle) begin
            o_lvl    <= !o_lvl;
            state    <= e_stable;
            filt_cnt <= '0;
        end else begin
            state    <= e_pend;
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // A new event beats a simultaneous clear for both flag and counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_edge    <= 1'b0;
            o_pending <= 1'b0;
            o_count   <= '0;
        end else begin
            o_edge <= event_now;
            if (event_now) begin
                o_pending <= 1'b1;
            end else if (i_clr) begin
                o_pending <= 1'b0;
            end
            if (i_clr) begin
                o_count <= CNT_W'(event_now);
            end else if (event_now && (o_count != '1)) begin
                o_count <= o_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_event_unit.sv
// N_CH independent edge event channels with an aggregated interrupt.
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_lvl,
    input  logic [2*N_CH-1:0]     i_mode,
    input  logic [N_CH-1:0]       i_clr,
    input  logic [N_CH-1:0]       i_irq_en,
    output logic [N_CH-1:0]       o_lvl,
    output logic [N_CH-1:0]       o_edge,
    output logic [N_CH-1:0]       o_pending,
    output logic [N_CH*CNT_W-1:0] o_count,
    output logic                  o_irq
);

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_chan
            edge_event_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_CYC   (FILT_CYC),
                .CNT_W      (CNT_W)
            ) u_chan (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_lvl    (i_lvl[k]),
                .i_mode   (t_edge_mode'(i_mode[2*k +: 2])),
                .i_clr    (i_clr[k]),
                .o_lvl    (o_lvl[k]),
                .o_edge   (o_edge[k]),
                .o_pending(o_pending[k]),
                .o_count  (o_count[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign o_irq = |(o_pending & i_irq_en);

endmodule

// File: tb/tb_edge_event_unit.sv
// Self-checking bench for edge_event_unit: directed tables, corner sequences
// and randomized traffic against a run-length reference model.
module tb_edge_event_unit;
    import edge_event_pkg::*;

    localparam int N_CH  = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic [N_CH-1:0]         i_lvl = '0;
    logic [2*N_CH-1:0]       i_mode = '0;
    logic [N_CH-1:0]         i_clr = '0;
    logic [N_CH-1:0]         i_irq_en = '0;

    logic [N_CH-1:0]         o_lvl, o_edge, o_pending;
    logic [N_CH*CNT_W-1:0]   o_count;
    logic                    o_irq;

    logic [N_CH-1:0]         s_lvl, s_edge, s_pending;
    logic [N_CH*SAT_W-1:0]   s_count;
    logic                    s_irq;

    edge_event_unit #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYC(FILT), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lvl(i_lvl), .i_mode(i_mode), .i_clr(i_clr),
        .i_irq_en(i_irq_en), .o_lvl(o_lvl), .o_edge(o_edge), .o_pending(o_pending),
        .o_count(o_count), .o_irq(o_irq)
    );

    edge_event_unit #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYC(FILT), .CNT_W(SAT_W)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lvl(i_lvl), .i_mode(i_mode), .i_clr(i_clr),
        .i_irq_en(i_irq_en), .o_lvl(s_lvl), .o_edge(s_edge), .o_pending(s_pending),
        .o_count(s_count), .o_irq(s_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int len; int exp_edges; } glitch_vec_t;
    typedef struct { t_edge_mode mode; int exp_edges; } mode_vec_t;
    typedef struct { logic [N_CH-1:0] en; logic exp_irq; } irq_vec_t;

    glitch_vec_t gtab[3];
    mode_vec_t   mtab[4];
    irq_vec_t    itab[2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw inputs delayed SYNC edges, then a run length of
    // samples differing from the accepted level.
    bit m_hist[N_CH][SYNC];
    bit m_lvl[N_CH];
    int m_run[N_CH];
    bit m_edge[N_CH];
    bit m_pend[N_CH];
    int m_cnt[N_CH];
    int m_cnt_sat[N_CH];
    int edge_seen[N_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            for (int j = 0; j < SYNC; j++) m_hist[k][j] = 1'b0;
            m_lvl[k] = 1'b0;
            m_run[k] = 0;
            m_edge[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_cnt[k] = 0;
            m_cnt_sat[k] = 0;
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        int limit;
        limit = (1 << w) - 1;
        return (v < limit) ? v + 1 : v;
    endfunction

    task automatic model_update();
        for (int k = 0; k < N_CH; k++) begin
            bit samp, old, ev;
            logic [1:0] md;
            samp = m_hist[k][SYNC-1];
            for (int j = SYNC - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = i_lvl[k];
            md = i_mode[2*k +: 2];
            ev = 1'b0;
            if (samp != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == FILT) begin
                    old = m_lvl[k];
                    m_lvl[k] = ~old;
                    m_run[k] = 0;
                    ev = old ? md[1] : md[0];
                end
            end else begin
                m_run[k] = 0;
            end
            m_edge[k] = ev;
            if (i_clr[k]) begin
                m_cnt[k] = ev ? 1 : 0;
                m_cnt_sat[k] = ev ? 1 : 0;
            end else if (ev) begin
                m_cnt[k] = sat_inc(m_cnt[k], CNT_W);
                m_cnt_sat[k] = sat_inc(m_cnt_sat[k], SAT_W);
            end
            if (ev) m_pend[k] = 1'b1;
            else if (i_clr[k]) m_pend[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0]       e_lvl, e_edge, e_pend;
        logic [N_CH*CNT_W-1:0] e_cnt;
        logic [N_CH*SAT_W-1:0] e_sat;
        for (int k = 0; k < N_CH; k++) begin
            e_lvl[k] = m_lvl[k];
            e_edge[k] = m_edge[k];
            e_pend[k] = m_pend[k];
            e_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
            e_sat[k*SAT_W +: SAT_W] = SAT_W'(m_cnt_sat[k]);
        end
        check("model_lvl", 32'(o_lvl), 32'(e_lvl));
        check("model_edge", 32'(o_edge), 32'(e_edge));
        check("model_pending", 32'(o_pending), 32'(e_pend));
        check("model_count", o_count, e_cnt);
        check("model_count_sat", 32'(s_count), 32'(e_sat));
        check("model_irq", 32'(o_irq), 32'(|(e_pend & i_irq_en)));
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
        compare_all();
        for (int k = 0; k < N_CH; k++) if (o_edge[k]) edge_seen[k]++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        gtab[0] = '{3, 0};
        gtab[1] = '{4, 2};
        gtab[2] = '{5, 2};
        mtab[0] = '{e_off, 0};
        mtab[1] = '{e_rise, 1};
        mtab[2] = '{e_fall, 1};
        mtab[3] = '{e_both, 2};
        itab[0] = '{4'b0010, 1'b1};
        itab[1] = '{4'b1101, 1'b0};
        for (int k = 0; k < N_CH; k++) edge_seen[k] = 0;

        // Reset state
        model_reset();
        #12;
        compare_all();
        #1 i_rst_n = 1'b1;

        // Basic rise on ch0: pulse follows the 6th sampling edge
        i_mode[1:0] = e_rise;
        i_lvl[0] = 1'b1;
        repeat (5) begin
            tick();
            check("t1_no_early_edge", 32'(o_edge[0]), 32'd0);
        end
        tick();
        check("t1_edge", 32'(o_edge[0]), 32'd1);
        check("t1_lvl", 32'(o_lvl[0]), 32'd1);
        check("t1_pending", 32'(o_pending[0]), 32'd1);
        check("t1_count", 32'(o_count[7:0]), 32'd1);
        tick();
        check("t1_edge_one_cycle", 32'(o_edge[0]), 32'd0);

        // Glitch rejection on ch1
        i_mode[3:2] = e_both;
        for (int i = 0; i < 3; i++) begin
            edge_seen[1] = 0;
            i_lvl[1] = 1'b1;
            repeat (gtab[i].len) tick();
            i_lvl[1] = 1'b0;
            repeat (12) tick();
            check($sformatf("glitch_len%0d_edges", gtab[i].len), 32'(edge_seen[1]), 32'(gtab[i].exp_edges));
        end
        check("glitch_count", 32'(o_count[15:8]), 32'd4);

        // Mode coverage on ch2
        for (int i = 0; i < 4; i++) begin
            i_mode[5:4] = mtab[i].mode;
            edge_seen[2] = 0;
            i_lvl[2] = 1'b1;
            repeat (10) tick();
            check("mode_lvl_high", 32'(o_lvl[2]), 32'd1);
            i_lvl[2] = 1'b0;
            repeat (10) tick();
            check("mode_lvl_low", 32'(o_lvl[2]), 32'd0);
            check($sformatf("mode%0d_edges", i), 32'(edge_seen[2]), 32'(mtab[i].exp_edges));
        end

        // Clear colliding with a new ch0 event
        i_lvl[0] = 1'b0;
        repeat (10) tick();
        check("coll_pre_pending", 32'(o_pending[0]), 32'd1);
        i_lvl[0] = 1'b1;
        repeat (5) tick();
        i_clr[0] = 1'b1;
        tick();
        i_clr[0] = 1'b0;
        check("coll_edge", 32'(o_edge[0]), 32'd1);
        check("coll_pending", 32'(o_pending[0]), 32'd1);
        check("coll_count", 32'(o_count[7:0]), 32'd1);

        // Saturation on ch3 (2-bit counter instance)
        i_mode[7:6] = e_both;
        for (int i = 0; i < 5; i++) begin
            i_lvl[3] = ~i_lvl[3];
            repeat (8) tick();
        end
        check("sat_count_sticks", 32'(s_count[7:6]), 32'd3);
        check("sat_wide_count", 32'(o_count[31:24]), 32'd5);
        i_clr[3] = 1'b1;
        tick();
        i_clr[3] = 1'b0;
        check("sat_clr_count", 32'(s_count[7:6]), 32'd0);
        check("sat_clr_wide", 32'(o_count[31:24]), 32'd0);
        check("sat_clr_pending", 32'(o_pending[3]), 32'd0);

        // IRQ masking with pending on ch1 only
        i_clr = '1;
        tick();
        i_clr = '0;
        check("irq_cleared", 32'(o_pending), 32'd0);
        i_lvl[1] = 1'b1;
        repeat (8) tick();
        check("irq_pending_ch1", 32'(o_pending), 32'b0010);
        for (int i = 0; i < 2; i++) begin
            i_irq_en = itab[i].en;
            #1;
            check($sformatf("irq_en_%b", itab[i].en), 32'(o_irq), 32'(itab[i].exp_irq));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 5) == 0) i_lvl[k] = ~i_lvl[k];
                if ($urandom_range(0, 31) == 0) i_mode[2*k +: 2] = 2'($urandom_range(0, 3));
                i_clr[k] = ($urandom_range(0, 15) == 0);
            end
            i_irq_en = 4'($urandom);
        end

        // Async reset in the middle of filtering
        i_clr = '0;
        i_mode = '1;
        for (int k = 0; k < N_CH; k++) i_lvl[k] = ~m_lvl[k];
        repeat (4) tick();
        #3 i_rst_n = 1'b0;
        #1;
        check("arst_lvl", 32'(o_lvl), 32'd0);
        check("arst_edge", 32'(o_edge), 32'd0);
        check("arst_pending", 32'(o_pending), 32'd0);
        check("arst_count", o_count, 32'd0);
        check("arst_count_sat", 32'(s_count), 32'd0);
        check("arst_irq", 32'(o_irq), 32'd0);
        model_reset();
        i_lvl = '0;
        for (int k = 0; k < N_CH; k++) edge_seen[k] = 0;
        @(negedge i_clk) i_rst_n = 1'b1;
        repeat (12) tick();
        total = 0;
        for (int k = 0; k < N_CH; k++) total += edge_seen[k];
        check("arst_no_residual_edge", 32'(total), 32'd0);
        check("arst_lvl_after", 32'(o_lvl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
